// File: rtl/theremin_led_fader.sv
// Ramps backlight brightness and two RGB LED colours toward software-loaded targets, one LSB per step.
// Optional THEREMIN_FADER_DONE_IRQ_EN adds a one-cycle DONE_IRQ pulse when a fade completes on its own.
module theremin_led_fader #(
  parameter int PRESCALE = 37500,
  parameter int RATE_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOAD,
  input  logic [7:0]        TARGET_BRIGHTNESS,
  input  logic [11:0]       TARGET_COLOR0,
  input  logic [11:0]       TARGET_COLOR1,
  input  logic [RATE_W-1:0] FADE_RATE,
  output logic [7:0]        BACKLIGHT_BRIGHTNESS,
  output logic [11:0]       RGB_LED_COLOR0,
  output logic [11:0]       RGB_LED_COLOR1,
`ifdef THEREMIN_FADER_DONE_IRQ_EN
  output logic              DONE_IRQ,
`endif
  output logic              BUSY
);
  localparam logic [15:0] PMAX = 16'(PRESCALE - 1);

  typedef enum logic {IDLE, FADE} state_t;

  state_t                r_state;
  logic [7:0]            r_tb;
  logic [5:0][3:0]       r_tn;
  logic [RATE_W-1:0]     r_rate;
  logic [RATE_W-1:0]     r_cnt;
  logic [15:0]           r_pre;
  logic                  r_irq;

  logic [5:0][3:0]       w_cur;
  logic [5:0][3:0]       w_nn;
  logic [7:0]            w_nb;
  logic                  w_tick, w_step, w_done, w_same;

  function automatic logic [7:0] toward8(input logic [7:0] c, input logic [7:0] t);
    return (c < t) ? c + 8'd1 : (c > t) ? c - 8'd1 : c;
  endfunction

  function automatic logic [3:0] toward4(input logic [3:0] c, input logic [3:0] t);
    return (c < t) ? c + 4'd1 : (c > t) ? c - 4'd1 : c;
  endfunction

  assign w_cur = {RGB_LED_COLOR1, RGB_LED_COLOR0};
  assign w_nb  = toward8(BACKLIGHT_BRIGHTNESS, r_tb);

  for (genvar i = 0; i < 6; i++) begin : g_nib
    assign w_nn[i] = toward4(w_cur[i], r_tn[i]);
  end

  assign w_tick = (r_pre == PMAX);
  assign w_step = w_tick && (r_cnt == r_rate - 1'b1);
  assign w_done = (w_nb == r_tb) && (w_nn == r_tn);
  assign w_same = (TARGET_BRIGHTNESS == BACKLIGHT_BRIGHTNESS) &&
                  ({TARGET_COLOR1, TARGET_COLOR0} == {RGB_LED_COLOR1, RGB_LED_COLOR0});

  assign BUSY = (r_state == FADE);
`ifdef THEREMIN_FADER_DONE_IRQ_EN
  assign DONE_IRQ = r_irq;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state              <= IDLE;
      r_tb                 <= '0;
      r_tn                 <= '0;
      r_rate               <= '0;
      r_cnt                <= '0;
      r_pre                <= '0;
      r_irq                <= 1'b0;
      BACKLIGHT_BRIGHTNESS <= '0;
      RGB_LED_COLOR0       <= '0;
      RGB_LED_COLOR1       <= '0;
    end else begin
      r_irq <= 1'b0;
      if (LOAD) begin
        // LOAD always restarts timing; a coincident step is dropped
        r_tb   <= TARGET_BRIGHTNESS;
        r_tn   <= {TARGET_COLOR1, TARGET_COLOR0};
        r_rate <= FADE_RATE;
        r_pre  <= '0;
        r_cnt  <= '0;
        if (FADE_RATE == '0) begin
          BACKLIGHT_BRIGHTNESS <= TARGET_BRIGHTNESS;
          RGB_LED_COLOR0       <= TARGET_COLOR0;
          RGB_LED_COLOR1       <= TARGET_COLOR1;
          r_state              <= IDLE;
        end else if (w_same) begin
          r_state <= IDLE;
        end else begin
          r_state <= FADE;
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_pre <= '0;
            r_cnt <= '0;
          end
          FADE: begin
            if (w_tick) begin
              r_pre <= '0;
              if (w_step) begin
                r_cnt                <= '0;
                BACKLIGHT_BRIGHTNESS <= w_nb;
                {RGB_LED_COLOR1, RGB_LED_COLOR0} <= w_nn;
                if (w_done) begin
                  r_state <= IDLE;
                  r_irq   <= 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_pre <= r_pre + 16'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_theremin_led_fader.sv
// Directed and randomized bench for theremin_led_fader, checked every cycle against a cycle-count model.
module tb_theremin_led_fader;
  localparam int P = 4;

  logic        CLK = 1'b0;
  logic        RESET, LOAD;
  logic [7:0]  TARGET_BRIGHTNESS;
  logic [11:0] TARGET_COLOR0, TARGET_COLOR1;
  logic [7:0]  FADE_RATE;
  logic [7:0]  BACKLIGHT_BRIGHTNESS;
  logic [11:0] RGB_LED_COLOR0, RGB_LED_COLOR1;
  logic        BUSY;
  logic        irq;

  theremin_led_fader #(.PRESCALE(P), .RATE_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD(LOAD),
    .TARGET_BRIGHTNESS(TARGET_BRIGHTNESS), .TARGET_COLOR0(TARGET_COLOR0),
    .TARGET_COLOR1(TARGET_COLOR1), .FADE_RATE(FADE_RATE),
    .BACKLIGHT_BRIGHTNESS(BACKLIGHT_BRIGHTNESS), .RGB_LED_COLOR0(RGB_LED_COLOR0),
    .RGB_LED_COLOR1(RGB_LED_COLOR1),
`ifdef THEREMIN_FADER_DONE_IRQ_EN
    .DONE_IRQ(irq),
`endif
    .BUSY(BUSY)
  );
`ifndef THEREMIN_FADER_DONE_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_err = 0;

  // model: channel values as plain integers, fade progress as cycles elapsed since LOAD
  int m_b, m_tb, m_rate, m_cnt;
  int m_c[6], m_tc[6];
  bit m_busy, m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nib(input logic [23:0] v, input int i);
    return int'(v[i*4 +: 4]);
  endfunction

  task automatic model_edge();
    logic [23:0] tc;
    bit same, all_eq;
    tc = {TARGET_COLOR1, TARGET_COLOR0};
    m_irq = 0;
    if (RESET) begin
      m_b = 0; m_busy = 0; m_cnt = 0; m_rate = 0; m_tb = 0;
      for (int i = 0; i < 6; i++) begin m_c[i] = 0; m_tc[i] = 0; end
    end else if (LOAD) begin
      same = (int'(TARGET_BRIGHTNESS) == m_b);
      for (int i = 0; i < 6; i++) if (nib(tc, i) != m_c[i]) same = 0;
      m_tb = int'(TARGET_BRIGHTNESS); m_rate = int'(FADE_RATE); m_cnt = 0;
      for (int i = 0; i < 6; i++) m_tc[i] = nib(tc, i);
      if (m_rate == 0) begin
        m_b = m_tb;
        for (int i = 0; i < 6; i++) m_c[i] = m_tc[i];
        m_busy = 0;
      end else m_busy = !same;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt % (m_rate * P) == 0) begin
        if (m_b < m_tb) m_b++; else if (m_b > m_tb) m_b--;
        all_eq = (m_b == m_tb);
        for (int i = 0; i < 6; i++) begin
          if (m_c[i] < m_tc[i]) m_c[i]++; else if (m_c[i] > m_tc[i]) m_c[i]--;
          if (m_c[i] != m_tc[i]) all_eq = 0;
        end
        if (all_eq) begin m_busy = 0; m_irq = 1; end
      end
    end
  endtask

  task automatic cyc();
    logic [23:0] ec;
    @(posedge CLK);
    model_edge();
    #1;
    for (int i = 0; i < 6; i++) ec[i*4 +: 4] = 4'(m_c[i]);
    chk("bright", 32'(BACKLIGHT_BRIGHTNESS), 32'(m_b));
    chk("color0", 32'(RGB_LED_COLOR0), 32'(ec[11:0]));
    chk("color1", 32'(RGB_LED_COLOR1), 32'(ec[23:12]));
    chk("busy", 32'(BUSY), 32'(m_busy));
`ifdef THEREMIN_FADER_DONE_IRQ_EN
    chk("done_irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic scramble();
    TARGET_BRIGHTNESS = 8'($urandom);
    TARGET_COLOR0 = 12'($urandom);
    TARGET_COLOR1 = 12'($urandom);
    FADE_RATE = 8'($urandom);
  endtask

  task automatic load(input logic [7:0] b, input logic [11:0] c0, input logic [11:0] c1,
                      input logic [7:0] rate);
    TARGET_BRIGHTNESS = b; TARGET_COLOR0 = c0; TARGET_COLOR1 = c1; FADE_RATE = rate;
    LOAD = 1'b1;
    cyc();
    LOAD = 1'b0;
    scramble();
  endtask

  task automatic run_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (m_busy && k < budget) begin cyc(); k++; end
    if (m_busy) chk({tag, "_timeout"}, 32'(k), 32'(budget + 1));
  endtask

  task automatic measure(output int k, output int irqs);
    k = 0; irqs = 0;
    while (BUSY === 1'b1 && k < 1000) begin cyc(); k++; if (irq === 1'b1) irqs++; end
  endtask

  initial begin
    int k, irqs;
    RESET = 1'b1; LOAD = 1'b1;
    TARGET_BRIGHTNESS = 8'hff; TARGET_COLOR0 = 12'hfff; TARGET_COLOR1 = 12'hfff; FADE_RATE = 8'd1;
    repeat (8) cyc();
    RESET = 1'b0; LOAD = 1'b0;
    repeat (10) begin scramble(); cyc(); end
    chk("reset_bright", 32'(BACKLIGHT_BRIGHTNESS), 32'd0);

    // basic ramp 0 -> 3 at rate 1
    load(8'd3, 12'h000, 12'h000, 8'd1);
    measure(k, irqs);
    chk("ramp_len", 32'(k), 32'd12);
    chk("ramp_val", 32'(BACKLIGHT_BRIGHTNESS), 32'd3);
`ifdef THEREMIN_FADER_DONE_IRQ_EN
    chk("ramp_irqs", 32'(irqs), 32'd1);
`endif
    repeat (5) cyc();

    // mixed directions
    load(8'd0, 12'hf40, 12'hc82, 8'd0);
    load(8'd0, 12'h0c4, 12'hc82, 8'd2);
    measure(k, irqs);
    chk("mixed_len", 32'(k), 32'd120);
    chk("mixed_c0", 32'(RGB_LED_COLOR0), 32'h0c4);

    // immediate jump
    load(8'd255, 12'hfff, 12'heee, 8'd0);
    chk("jump_b", 32'(BACKLIGHT_BRIGHTNESS), 32'd255);
    chk("jump_c1", 32'(RGB_LED_COLOR1), 32'heee);
    repeat (6) cyc();

    // no-op load: same targets, nonzero rate
    load(8'd255, 12'hfff, 12'heee, 8'd3);
    chk("noop_busy", 32'(BUSY), 32'd0);
    repeat (4) cyc();

    // retarget mid-fade
    load(8'd0, 12'h000, 12'h000, 8'd0);
    load(8'd64, 12'h000, 12'h000, 8'd1);
    k = 0;
    while (BACKLIGHT_BRIGHTNESS != 8'd20 && k < 500) begin cyc(); k++; end
    chk("retarget_reach", 32'(BACKLIGHT_BRIGHTNESS), 32'd20);
    load(8'd8, 12'h000, 12'h000, 8'd1);
    chk("retarget_nojump", 32'(BACKLIGHT_BRIGHTNESS), 32'd20);
    repeat (P) cyc();
    chk("retarget_first", 32'(BACKLIGHT_BRIGHTNESS), 32'd19);
    run_idle("retarget", 500);
    chk("retarget_end", 32'(BACKLIGHT_BRIGHTNESS), 32'd8);

    // reset mid-fade
    load(8'd200, 12'h000, 12'h000, 8'd1);
    k = 0;
    while (BACKLIGHT_BRIGHTNESS != 8'd100 && k < 1000) begin cyc(); k++; end
    chk("rst_reach", 32'(BACKLIGHT_BRIGHTNESS), 32'd100);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    chk("rst_mid_b", 32'(BACKLIGHT_BRIGHTNESS), 32'd0);
    chk("rst_mid_busy", 32'(BUSY), 32'd0);
    repeat (5) cyc();

    // random loads, often superseding a fade in progress
    for (int n = 0; n < 40; n++) begin
      load(8'($urandom), 12'($urandom), 12'($urandom), 8'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 150)) begin scramble(); cyc(); end
    end
    run_idle("random_tail", 4000);
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
